// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU sequencer: FSM states, op4 classes and
// the ALU opcodes that never write the register file.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'd0;
  localparam logic [3:0] OP_JZ   = 4'd1;
  localparam logic [3:0] OP_JNZ  = 4'd2;
  localparam logic [3:0] OP_JC   = 4'd3;
  localparam logic [3:0] OP_JNC  = 4'd4;
  localparam logic [3:0] OP_JN   = 4'd5;
  localparam logic [3:0] OP_LI   = 4'd6;
  localparam logic [3:0] OP_LM   = 4'd7;
  localparam logic [3:0] OP_ST   = 4'd8;
  localparam logic [3:0] OP_LDIP = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [8:0] ALU_NOP      = 9'd0;
  localparam logic [8:0] ALU_SHOWR    = 9'd18;
  localparam logic [8:0] ALU_SHOWRSEG = 9'd19;

  // op4 sits directly below the class bit; aluOp spans the same upper field
  function automatic logic [3:0] op4_of(input logic [15:0] inst);
    return inst[14:11];
  endfunction

  function automatic logic [8:0] alu_op_of(input logic [15:0] inst);
    return inst[14:6];
  endfunction

endpackage

// File: rtl/cpu_branch_unit.sv
// Jump condition evaluation: decides whether a jump instruction is taken
// from its op4 and the ALU flags.
module cpu_branch_unit
  import cpu_pkg::*;
(
  input  logic [3:0] op4,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (op4)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = flag_z;
      OP_JNZ:  taken = ~flag_z;
      OP_JC:   taken = flag_c;
      OP_JNC:  taken = ~flag_c;
      OP_JN:   taken = flag_n;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer: drives the memory handshakes,
// register-file write strobes and the program counter of the 16-bit CPU.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [INST_W-1:0] i_imem_data,
  output logic [INST_W-1:0] o_inst,
  input  logic              i_isJump,
  input  logic              i_isLoad,
  input  logic              i_isStore,
  input  logic              i_rw,
  input  logic              i_flag_z,
  input  logic              i_flag_c,
  input  logic              i_flag_n,
  output logic              o_alu_en,
  output logic              o_rf_we,
  output logic              o_rf_wsel,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  input  logic              i_dmem_ack,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_halt,
  output logic [2:0]        o_state
);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [3:0]          op4;
  logic [8:0]          alu_op;
  logic                is_halt_op;
  logic                is_li;
  logic                is_mem_load;
  logic                alu_writes;
  logic                taken;

  assign op4         = op4_of(inst_q);
  assign alu_op      = alu_op_of(inst_q);
  assign is_halt_op  = inst_q[15] && (op4 == OP_HALT);
  assign is_li       = i_isLoad && (op4 == OP_LI);
  assign is_mem_load = i_isLoad && ((op4 == OP_LM) || (op4 == OP_LDIP));
  assign alu_writes  = !((alu_op == ALU_NOP) || (alu_op == ALU_SHOWR) ||
                         (alu_op == ALU_SHOWRSEG));

  cpu_branch_unit u_branch (
    .op4    (op4),
    .flag_z (i_flag_z),
    .flag_c (i_flag_c),
    .flag_n (i_flag_n),
    .taken  (taken)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    o_imem_req = 1'b0;
    o_alu_en   = 1'b0;
    o_rf_we    = 1'b0;
    o_rf_wsel  = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_halt     = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          inst_d  = i_imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt_op)                   state_d = S_HALT;
        else if (is_mem_load || i_isStore) state_d = S_MEM;
        else                              state_d = S_EXEC;
      end
      S_EXEC: begin
        // PC already points past this instruction, so only a taken jump moves it
        if (!inst_q[15]) begin
          o_alu_en = 1'b1;
          o_rf_we  = i_rw && alu_writes;
        end else if (is_li) begin
          o_rf_we   = 1'b1;
          o_rf_wsel = 1'b1;
        end else if (i_isJump && taken) begin
          pc_d = inst_q[PC_W-1:0];
        end
        state_d = S_FETCH;
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (op4 == OP_ST);
        if (i_dmem_ack) state_d = o_dmem_we ? S_FETCH : S_WB;
      end
      S_WB: begin
        o_rf_we   = 1'b1;
        o_rf_wsel = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        o_halt = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // Reset is asynchronous: strobes and requests must drop with it, not at the next edge
    if (i_rst) begin
      o_imem_req = 1'b0;
      o_alu_en   = 1'b0;
      o_rf_we    = 1'b0;
      o_rf_wsel  = 1'b0;
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      o_halt     = 1'b0;
    end
  end

  assign o_imem_addr = pc_q;
  assign o_pc        = pc_q;
  assign o_inst      = inst_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: memory responders issue a program and
// push the instruction-level expected events; a monitor pops and compares.
module tb_cpu_seq_ctrl;

  localparam int EV_FETCH = 0;
  localparam int EV_ALU   = 1;
  localparam int EV_RFWE  = 2;
  localparam int EV_DMEM  = 3;
  localparam int EV_HALT  = 4;

  typedef struct { int kind; int val; int cyc; } ev_t;
  typedef struct { logic [15:0] inst; bit z; bit c; bit n; int w; } prog_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req;
  logic [7:0]  o_imem_addr;
  logic        i_imem_ack;
  logic [15:0] i_imem_data;
  logic [15:0] o_inst;
  logic        i_isJump, i_isLoad, i_isStore, i_rw;
  logic        i_flag_z, i_flag_c, i_flag_n;
  logic        o_alu_en, o_rf_we, o_rf_wsel, o_dmem_req, o_dmem_we;
  logic        i_dmem_ack;
  logic [7:0]  o_pc;
  logic        o_halt;
  logic [2:0]  o_state;

  ev_t   exp_q[$];
  prog_t prog_q[$];
  int    wq[$];
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  int    model_pc = 0;
  int    halt_req_seen = 0;
  bit    halted = 1'b0;

  cpu_seq_ctrl #(.PC_W(8), .INST_W(16), .RESET_PC(8'h00)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_data (i_imem_data),
    .o_inst      (o_inst),
    .i_isJump    (i_isJump),
    .i_isLoad    (i_isLoad),
    .i_isStore   (i_isStore),
    .i_rw        (i_rw),
    .i_flag_z    (i_flag_z),
    .i_flag_c    (i_flag_c),
    .i_flag_n    (i_flag_n),
    .o_alu_en    (o_alu_en),
    .o_rf_we     (o_rf_we),
    .o_rf_wsel   (o_rf_wsel),
    .o_dmem_req  (o_dmem_req),
    .o_dmem_we   (o_dmem_we),
    .i_dmem_ack  (i_dmem_ack),
    .o_pc        (o_pc),
    .o_halt      (o_halt),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Instruction decoder model
  assign i_isJump  = o_inst[15] && (o_inst[14:11] < 4'd6);
  assign i_isLoad  = o_inst[15] && ((o_inst[14:11] == 4'd6) || (o_inst[14:11] == 4'd7) ||
                                    (o_inst[14:11] == 4'd9));
  assign i_isStore = o_inst[15] && (o_inst[14:11] == 4'd8);
  assign i_rw      = (!o_inst[15] && (o_inst[14:6] != 9'd0) && (o_inst[14:6] != 9'd18) &&
                      (o_inst[14:6] != 9'd19)) || i_isLoad;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int val, input int cy);
    ev_t e;
    e.kind = kind; e.val = val; e.cyc = cy;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input int val, input string name);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event value %0d at cycle %0d, none required", name, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || (e.cyc >= 0 && e.cyc != cyc)) begin
        fails++;
        $display("FAIL %s: got kind %0d value %0d cycle %0d, required kind %0d value %0d cycle %0d",
                 name, kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  function automatic prog_t mk(input logic [15:0] inst, input bit z, input bit c, input bit n,
                               input int w);
    prog_t p;
    p.inst = inst; p.z = z; p.c = c; p.n = n; p.w = w;
    return p;
  endfunction

  function automatic prog_t rand_prog();
    logic [15:0] x;
    logic [8:0]  aop;
    x = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin
        aop = x[14:6];
        case ($urandom_range(0, 5))
          0: aop = 9'd0;
          1: aop = 9'd18;
          2: aop = 9'd19;
          default: ;
        endcase
        x = {1'b0, aop, x[5:0]};
      end
      4, 5, 6: x[15:11] = {1'b1, 4'($urandom_range(0, 5))};
      7:       x[15:11] = {1'b1, 4'd6};
      8:       x[15:11] = {1'b1, ($urandom_range(0, 1) != 0) ? 4'd7 : 4'd9};
      default: x[15:11] = {1'b1, ($urandom_range(0, 1) != 0) ? 4'd8 : 4'($urandom_range(10, 14))};
    endcase
    return mk(x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
  endfunction

  // Instruction-level reference: what one fetched instruction must cause, and when
  task automatic issue(input prog_t p, input int c);
    int op, aop, npc;
    bit [5:0] conds;
    op   = int'(p.inst[14:11]);
    aop  = int'(p.inst[14:6]);
    npc  = (model_pc + 1) % 256;
    if (p.inst[15] && op == 15) begin
      push_ev(EV_HALT, 0, c + 2);
      return;
    end
    if (!p.inst[15]) begin
      push_ev(EV_ALU, 0, c + 2);
      if (!(aop == 0 || aop == 18 || aop == 19)) push_ev(EV_RFWE, 0, c + 2);
      push_ev(EV_FETCH, npc, c + 3);
    end else if (op < 6) begin
      conds = {p.n, !p.c, p.c, !p.z, p.z, 1'b1};
      if (conds[op]) npc = int'(p.inst[7:0]);
      push_ev(EV_FETCH, npc, c + 3);
    end else if (op == 6) begin
      push_ev(EV_RFWE, 1, c + 2);
      push_ev(EV_FETCH, npc, c + 3);
    end else if (op == 7 || op == 9) begin
      wq.push_back(p.w);
      push_ev(EV_DMEM, 0, c + 2);
      push_ev(EV_RFWE, 1, c + 3 + p.w);
      push_ev(EV_FETCH, npc, c + 4 + p.w);
    end else if (op == 8) begin
      wq.push_back(p.w);
      push_ev(EV_DMEM, 1, c + 2);
      push_ev(EV_FETCH, npc, c + 3 + p.w);
    end else begin
      push_ev(EV_FETCH, npc, c + 3);
    end
    model_pc = npc;
  endtask

  initial begin : imem_resp
    int iw, icnt;
    bit ibusy;
    prog_t p;
    i_imem_ack = 1'b0; i_imem_data = '0;
    i_flag_z = 1'b0; i_flag_c = 1'b0; i_flag_n = 1'b0;
    ibusy = 1'b0; iw = 0; icnt = 0;
    forever begin
      @(negedge i_clk);
      i_imem_ack = 1'b0;
      if (i_rst) begin
        ibusy = 1'b0;
        model_pc = 0;
        exp_q.delete();
        wq.delete();
        push_ev(EV_FETCH, 0, -1);
      end else if (o_imem_req) begin
        if (!ibusy) begin
          ibusy = 1'b1; icnt = 0; iw = $urandom_range(0, 2);
        end
        if (icnt == iw) begin
          p = (prog_q.size() > 0) ? prog_q.pop_front() : mk(16'hF800, 0, 0, 0, 0);
          i_imem_ack = 1'b1; i_imem_data = p.inst;
          i_flag_z = p.z; i_flag_c = p.c; i_flag_n = p.n;
          issue(p, cyc);
          ibusy = 1'b0;
        end else begin
          icnt++;
          i_imem_data = 16'($urandom);
        end
      end else begin
        i_imem_ack  = ($urandom_range(0, 3) == 0);
        i_imem_data = 16'($urandom);
      end
    end
  end

  initial begin : dmem_resp
    int dw, dcnt;
    bit dbusy;
    i_dmem_ack = 1'b0; dbusy = 1'b0; dw = 0; dcnt = 0;
    forever begin
      @(negedge i_clk);
      i_dmem_ack = 1'b0;
      if (i_rst) begin
        dbusy = 1'b0;
      end else if (o_dmem_req) begin
        if (!dbusy) begin
          dbusy = 1'b1; dcnt = 0;
          dw = (wq.size() > 0) ? wq.pop_front() : 0;
        end
        if (dcnt == dw) begin
          i_dmem_ack = 1'b1; dbusy = 1'b0;
        end else begin
          dcnt++;
        end
      end else begin
        i_dmem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin : monitor
    bit prev_req, prev_dreq, prev_halt, prev_we;
    prev_req = 1'b0; prev_dreq = 1'b0; prev_halt = 1'b0; prev_we = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_req = 1'b0; prev_dreq = 1'b0; prev_halt = 1'b0;
        halted = 1'b0;
      end else begin
        if (o_imem_req && !prev_req) expect_ev(EV_FETCH, int'(o_imem_addr), "fetch_addr");
        if (o_halt && !prev_halt) begin
          expect_ev(EV_HALT, 0, "halt");
          halted = 1'b1;
        end
        if (o_alu_en) expect_ev(EV_ALU, 0, "alu_en");
        if (o_rf_we) begin
          expect_ev(EV_RFWE, int'(o_rf_wsel), "rf_we");
          check("rf_we_with_dmem_req", int'(o_dmem_req), 0);
        end
        if (o_dmem_req && !prev_dreq) expect_ev(EV_DMEM, int'(o_dmem_we), "dmem_req");
        if (o_dmem_req && prev_dreq) check("dmem_we_stable", int'(o_dmem_we), int'(prev_we));
        if (halted && (o_imem_req || o_dmem_req)) halt_req_seen++;
        prev_req  = o_imem_req;
        prev_dreq = o_dmem_req;
        prev_halt = o_halt;
        prev_we   = o_dmem_we;
      end
    end
  end

  initial begin : main
    prog_q.push_back(mk(16'h0041, 0, 0, 0, 0));
    prog_q.push_back(mk(16'h8812, 1, 0, 0, 0));
    prog_q.push_back(mk(16'h8812, 0, 1, 1, 0));
    prog_q.push_back(mk(16'hB805, 0, 0, 0, 4));
    prog_q.push_back(mk(16'hC207, 0, 0, 0, 0));
    for (int i = 0; i < 150; i++) prog_q.push_back(rand_prog());
    prog_q.push_back(mk(16'h80FF, 0, 0, 0, 0));
    prog_q.push_back(mk(16'h0000, 0, 0, 0, 0));
    prog_q.push_back(mk(16'hF800, 0, 0, 0, 0));

    repeat (3) @(negedge i_clk);
    check("rst_state", int'(o_state), 0);
    check("rst_pc", int'(o_pc), 0);
    check("rst_inst", int'(o_inst), 0);
    check("rst_halt", int'(o_halt), 0);
    check("rst_imem_req", int'(o_imem_req), 0);
    check("rst_dmem_req", int'(o_dmem_req), 0);
    check("rst_rf_we", int'(o_rf_we), 0);
    check("rst_alu_en", int'(o_alu_en), 0);
    #2 i_rst = 1'b0;

    for (int k = 0; k < 20000 && !o_halt; k++) @(negedge i_clk);
    check("halt_reached", int'(o_halt), 1);
    repeat (5) @(negedge i_clk);
    check("no_req_in_halt", halt_req_seen, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    check("halt_pc", int'(o_pc), 1);
    check("halt_state", int'(o_state), 5);

    // Leave HALT by reset, then abandon a load that never completes
    prog_q.push_back(mk(16'hB805, 0, 0, 0, 1000));
    prog_q.push_back(mk(16'hF800, 0, 0, 0, 0));
    #2 i_rst = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    for (int k = 0; k < 50 && !o_dmem_req; k++) @(negedge i_clk);
    check("mem_reached", int'(o_dmem_req), 1);
    repeat (2) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("async_rst_dmem_req", int'(o_dmem_req), 0);
    check("async_rst_state", int'(o_state), 0);
    check("async_rst_pc", int'(o_pc), 0);
    check("async_rst_inst", int'(o_inst), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    for (int k = 0; k < 50 && !o_halt; k++) @(negedge i_clk);
    check("halt_after_rst", int'(o_halt), 1);
    repeat (3) @(negedge i_clk);
    check("scoreboard_drained_2", exp_q.size(), 0);
    check("halt_pc_2", int'(o_pc), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit CPU datapath.
- Fetches instructions from instruction memory and presents them to the instruction decoder.
- Uses decoder class outputs (jump/load/store/rw) and ALU flags to drive register-file write, data-memory handshake and program counter update.
- Sits between the instruction/data memories, the decoder, the register file and the ALU.

Parameters:
- PC_W, 8, program counter width; matches the 8-bit immediate/address field inst[7:0].
- INST_W, 16, instruction width.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- o_imem_req  out  1  instruction fetch request; held until ack.
- o_imem_addr  out  PC_W  fetch address (= PC).
- i_imem_ack  in  1  fetch data valid this cycle.
- i_imem_data  in  INST_W  fetched instruction.
- o_inst  out  INST_W  latched instruction register, drives decoder i_inst.
- i_isJump  in  1  decoder: msb=1, op4<6.
- i_isLoad  in  1  decoder: msb=1, op4 in {6,7,9}.
- i_isStore  in  1  decoder: msb=1, op4=8.
- i_rw  in  1  decoder: instruction writes the register file.
- i_flag_z, i_flag_c, i_flag_n  in  1 each  ALU flags; registered by the ALU and valid in EXEC.
- o_alu_en  out  1  ALU operation strobe (EXEC, ALU-class only).
- o_rf_we  out  1  register-file write strobe, one cycle.
- o_rf_wsel  out  1  write data select: 0 = ALU result, 1 = load data/immediate path.
- o_dmem_req  out  1  data memory request; held until ack.
- o_dmem_we  out  1  1 = store, 0 = read; valid while o_dmem_req.
- i_dmem_ack  in  1  data memory completion.
- o_pc  out  PC_W  current PC.
- o_halt  out  1  core halted.
- o_state  out  3  state encoding for debug.

Behaviour:
- Reset (async, any state): state=FETCH, PC=RESET_PC, o_inst=16'h0000 (NOP). All strobes and requests are 0, o_halt=0. Any outstanding memory request is abandoned with no completion.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and return to FETCH on the next edge.
- FETCH:
  - o_imem_req=1, o_imem_addr=PC.
  - On an edge with i_imem_ack=1: o_inst<=i_imem_data, PC<=PC+1 (wraps 8'hFF to 8'h00), go to DECODE.
  - An ack in the same cycle as the first req cycle is legal; minimum stay is 1 cycle.
- DECODE (1 cycle):
  - inst==16'hF800..16'hFFFF (msb=1, op4=15): go to HALT.
  - i_isLoad with op4=6 (Li): go to EXEC.
  - i_isLoad with op4=7 or 9: go to MEM, dmem_we=0.
  - i_isStore: go to MEM, dmem_we=1.
  - All other instructions (jump, ALU, NOP): go to EXEC.
- EXEC (1 cycle):
  - ALU class (msb=0): o_alu_en=1, o_rf_we=i_rw, o_rf_wsel=0. NOP (aluOp=0), showr and showrSeg produce rf_we=0.
  - Li: o_rf_we=1, o_rf_wsel=1.
  - Jump: condition by op4; 0 JMP always, 1 JZ z, 2 JNZ !z, 3 JC c, 4 JNC !c, 5 JN n.
    - Taken: PC<=inst[7:0].
    - Not taken: PC unchanged, since it already points to the next instruction.
  - Then go to FETCH.
- MEM:
  - o_dmem_req=1 and o_dmem_we are held stable until i_dmem_ack.
  - Store: on ack, go to FETCH.
  - Load: on ack, go to WB.
- WB (1 cycle): o_rf_we=1, o_rf_wsel=1, then go to FETCH.
- HALT: o_halt=1, no requests; exit only by reset.
- Cycle counts with zero-wait ack:
  - ALU / Li / jump: 3 cycles (F, D, E).
  - LM / LDip: 4 cycles (F, D, M, W).
  - Store: 3 cycles (F, D, M).
- o_rf_we is never asserted in the same cycle as o_dmem_req.
- A spurious ack outside the matching request state is ignored.
- Flags are sampled only in EXEC.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings;
  - op4 constants OP_JMP..OP_JN (0-5), OP_LI=6, OP_LM=7, OP_ST=8, OP_LDIP=9, OP_HALT=15;
  - aluOp constants NOP=9'd0, SHOWR=9'd18, SHOWRSEG=9'd19.
- One sub-module, cpu_branch_unit: combinational taken = f(op4, z, c, n).

Test Plan:
- Reset release with zero-wait imem, inst 16'h0041 (add r0,r1) at PC 0 → o_alu_en and o_rf_we high in cycle 3; PC=1; next fetch addr=1.
- Inst 16'h8812 (JZ, addr 0x12) with z=1 → PC=0x12; repeat with z=0 → PC=next sequential.
- Inst 16'hB805 (LM), dmem ack delayed 4 cycles → o_dmem_req held 5 cycles with we=0; one-cycle o_rf_we with wsel=1 after ack.
- Inst 16'hC207 (store), ack immediate → dmem_we=1 for 1 cycle; o_rf_we never asserted.
- PC=0xFF fetch of NOP → PC wraps to 0x00; fetch of 16'hF800 → o_halt=1 and no further o_imem_req.
- Assert i_rst mid-MEM with req pending → o_dmem_req drops asynchronously; after release, FETCH from addr 0x00.
